// File: rtl/alu_step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : alu_pkg
//  Purpose : Shared definitions for the ALU step sequencer: state encoding
//            (also the display code on state_out) and ALU opcode constants.
//  Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Sequencer states; the numeric code is what the board displays.
    typedef enum logic [2:0] {
        ST_LOAD_A    = 3'd0,
        ST_LOAD_B    = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_SHOW      = 3'd4
    } state_t;

    // Opcodes understood by the ALU core.
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;

endpackage
`default_nettype wire

// File: rtl/alu_step_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module  : btn_debounce
//  Purpose : Synchronises a raw push button, debounces it and emits a single
//            one-cycle press pulse on each debounced rising edge.
//  Ports   : clock   in  system clock
//            reset   in  asynchronous active-high reset
//            btn_raw in  raw button, asynchronous to clock
//            press   out one-cycle pulse per debounced push
//  Rev     : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Any sample equal to the current level restarts the run, so a
            // bounce only counts once it has been stable DEB_CYCLES samples.
            if (r_sync2 != r_level) begin
                if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign press = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/alu_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : alu_step_ctrl
//  Purpose : Button-driven sequencer for the 8-bit ALU datapath. Each press
//            of the step button advances: capture A -> capture B + opcode ->
//            start ALU -> hold result.
//  Ports   : clock, reset (async, active-high)
//            step_btn            raw step button
//            data_in, op_sel     operand / opcode switches
//            alu_a/b/op          registered operands and opcode to the ALU
//            alu_start           one-cycle start pulse (ISSUE state)
//            alu_done/result     ALU handshake and result
//            y_out, err          captured result / timeout flag
//            state_out, busy     display state code, busy in ISSUE/WAIT_DONE
//  Rev     : 1.0  initial release
// ============================================================================
module alu_step_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int OP_W       = 4,
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step_btn,
    input  logic [WIDTH-1:0] data_in,
    input  logic [OP_W-1:0]  op_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] y_out,
    output logic             err,
    output logic [2:0]       state_out,
    output logic             busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic             w_press;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [TW-1:0]    r_tcnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OP_W-1:0]  r_op;
    logic [WIDTH-1:0] r_y;
    logic             r_err;

    logic             w_cap_a;
    logic             w_cap_b;
    logic             w_y_load;
    logic [WIDTH-1:0] w_y_val;
    logic             w_err_set;
    logic             w_err_clr;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_start;
    logic             w_busy;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (step_btn),
        .press   (w_press)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_LOAD_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cap_a     = 1'b0;
        w_cap_b     = 1'b0;
        w_y_load    = 1'b0;
        w_y_val     = alu_result;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_start     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_LOAD_A, ST_SHOW: begin
                // SHOW starts a fresh sequence directly with operand A.
                if (w_press) begin
                    w_cap_a     = 1'b1;
                    w_err_clr   = 1'b1;
                    w_state_nxt = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (w_press) begin
                    w_cap_b     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_start   = 1'b1;
                w_busy    = 1'b1;
                w_cnt_clr = 1'b1;
                if (alu_done) begin
                    w_y_load    = 1'b1;
                    w_state_nxt = ST_SHOW;
                end else begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                w_busy = 1'b1;
                if (alu_done) begin
                    // A result arriving on the timeout cycle still wins.
                    w_y_load    = 1'b1;
                    w_state_nxt = ST_SHOW;
                end else begin
                    w_cnt_inc = 1'b1;
                    if (r_tcnt >= TW'(TIMEOUT - 1)) begin
                        w_y_load    = 1'b1;
                        w_y_val     = '0;
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_SHOW;
                    end
                end
            end
            default: w_state_nxt = ST_LOAD_A;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_y    <= '0;
            r_err  <= 1'b0;
            r_tcnt <= '0;
        end else begin
            if (w_cap_a) r_a <= data_in;
            if (w_cap_b) begin
                r_b  <= data_in;
                r_op <= op_sel;
            end
            if (w_y_load) r_y <= w_y_val;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
            if (w_cnt_clr) begin
                r_tcnt <= '0;
            end else if (w_cnt_inc && (r_tcnt != TW'(TIMEOUT))) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_op    = r_op;
    assign y_out     = r_y;
    assign err       = r_err;
    assign alu_start = w_start;
    assign busy      = w_busy;
    assign state_out = r_state;

endmodule
`default_nettype wire
